csc_mat_stor: RTL and testbench

Parametrised compressed-sparse-column (CSC) storage for the complex matrix datapath. Takes a column-major stream of non-zero entries, each with a row index and CH complex values (e.g. s, a0, a1). Builds the column-pointer array and entry memory, then serves column read requests as a valid/ready stream. Sits between the matrix-generation front end and the column-wise solver stages.

---
 rtl/csc_mat_stor.sv | 207 ++++++++++++++++++++
 tb/tb_csc_mat_stor.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csc_mat_stor.sv
// Compressed-sparse-column matrix store: builds col_ptr/entry memories from a column-major
// write stream and serves column reads as a valid/ready stream. Option: CSC_MAT_STOR_ORDER_CHK_EN.
module csc_mat_stor #(
  parameter int MAT_RANK = 256,
  parameter int NNZ_MAX  = 1024,
  parameter int DW       = 32,
  parameter int CH       = 3,
  localparam int RW = $clog2(MAT_RANK),
  localparam int PW = $clog2(NNZ_MAX + 1),
  localparam int VW = CH * 2 * DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_start,
  input  logic          wr_vld,
  output logic          wr_rdy,
  input  logic [RW-1:0] wr_col,
  input  logic [RW-1:0] wr_row,
  input  logic [VW-1:0] wr_val,
  input  logic          wr_last,
  input  logic          rd_req,
  input  logic [RW-1:0] rd_col,
  output logic          rd_busy,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [RW-1:0] rd_row,
  output logic [VW-1:0] rd_val,
  output logic          rd_last,
  output logic          rd_empty,
  output logic          done,
  output logic [PW-1:0] nnz,
  output logic          err_ovf,
  output logic          err_ord
);

  localparam int AW = (NNZ_MAX > 1) ? $clog2(NNZ_MAX) : 1;
  localparam logic [RW:0]   LAST_COL = (RW + 1)'(MAT_RANK - 1);
  localparam logic [PW-1:0] NNZ_FULL = PW'(NNZ_MAX);

  typedef enum logic [2:0] {IDLE, LOAD, SEAL, RDY, RPTR, RD} state_t;

  state_t        state;
  logic [RW:0]   cur_col;
  logic [RW-1:0] rd_c;
  logic          rptr_ph;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_end;

  logic [PW-1:0]    col_ptr [0:MAT_RANK];
  logic [RW+VW-1:0] ent_mem [0:NNZ_MAX-1];

  logic             col_step;
  logic             wr_bad_ord;
  logic             wr_full;
  logic             ent_we;
  logic             ptr_we;
  logic [RW:0]      ptr_wa;
  logic [PW-1:0]    ptr_wd;
  logic [RW+VW-1:0] rd_word;
  logic             next_last;

  // A write for a later column stalls the stream while col_ptr catches up one column per cycle.
  assign col_step = wr_vld && ({1'b0, wr_col} > cur_col);
  assign wr_rdy   = (state == LOAD) && !col_step;
  assign wr_full  = (nnz == NNZ_FULL);

`ifdef CSC_MAT_STOR_ORDER_CHK_EN
  logic err_ord_q;
  assign wr_bad_ord = ({1'b0, wr_col} < cur_col);
  assign err_ord    = err_ord_q;
`else
  assign wr_bad_ord = 1'b0;
  assign err_ord    = 1'b0;
`endif

  assign ent_we = !wr_start && wr_rdy && wr_vld && !wr_bad_ord && !wr_full;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    ptr_we = 1'b0;
    ptr_wa = '0;
    ptr_wd = '0;
    if (wr_start) begin
      ptr_we = 1'b1;
    end else if ((state == LOAD && col_step) || state == SEAL) begin
      ptr_we = 1'b1;
      ptr_wa = cur_col + 1'b1;
      ptr_wd = nnz;
    end
  end

  // NOTE: storage arrays have no reset; only control state is reset, contents are rebuilt per load.
  always_ff @(posedge clk) begin
    if (ptr_we) col_ptr[ptr_wa] <= ptr_wd;
    if (ent_we) ent_mem[nnz[AW-1:0]] <= {wr_row, wr_val};
  end

  assign rd_word   = ent_mem[rd_ptr[AW-1:0]];
  assign next_last = ((rd_ptr + 1'b1) == rd_end);

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_col  <= '0;
      rd_c     <= '0;
      rptr_ph  <= 1'b0;
      rd_ptr   <= '0;
      rd_end   <= '0;
      rd_busy  <= 1'b0;
      rd_vld   <= 1'b0;
      rd_row   <= '0;
      rd_val   <= '0;
      rd_last  <= 1'b0;
      rd_empty <= 1'b0;
      done     <= 1'b0;
      nnz      <= '0;
      err_ovf  <= 1'b0;
`ifdef CSC_MAT_STOR_ORDER_CHK_EN
      err_ord_q <= 1'b0;
`endif
    end else begin
      rd_empty <= 1'b0;
      if (wr_start) begin
        state   <= LOAD;
        cur_col <= '0;
        nnz     <= '0;
        done    <= 1'b0;
        err_ovf <= 1'b0;
        rd_busy <= 1'b0;
        rd_vld  <= 1'b0;
        rd_last <= 1'b0;
`ifdef CSC_MAT_STOR_ORDER_CHK_EN
        err_ord_q <= 1'b0;
`endif
      end else begin
        case (state)
          LOAD: begin
            if (col_step) begin
              cur_col <= cur_col + 1'b1;
            end else if (wr_vld) begin
`ifdef CSC_MAT_STOR_ORDER_CHK_EN
              if (wr_bad_ord) err_ord_q <= 1'b1;
              else
`endif
              if (wr_full) err_ovf <= 1'b1;
              else         nnz     <= nnz + 1'b1;
              if (wr_last) state <= SEAL;
            end
          end
          SEAL: begin
            if (cur_col == LAST_COL) begin
              state <= RDY;
              done  <= 1'b1;
            end else begin
              cur_col <= cur_col + 1'b1;
            end
          end
          RDY: begin
            if (rd_req) begin
              rd_c    <= rd_col;
              rptr_ph <= 1'b0;
              rd_busy <= 1'b1;
              state   <= RPTR;
            end
          end
          RPTR: begin
            if (!rptr_ph) begin
              rd_ptr  <= col_ptr[{1'b0, rd_c}];
              rd_end  <= col_ptr[{1'b0, rd_c} + 1'b1];
              rptr_ph <= 1'b1;
            end else if (rd_ptr == rd_end) begin
              rd_empty <= 1'b1;
              rd_busy  <= 1'b0;
              state    <= RDY;
            end else begin
              rd_vld  <= 1'b1;
              rd_row  <= rd_word[RW+VW-1:VW];
              rd_val  <= rd_word[VW-1:0];
              rd_last <= next_last;
              rd_ptr  <= rd_ptr + 1'b1;
              state   <= RD;
            end
          end
          RD: begin
            // The output register refills on every accepted beat and holds otherwise.
            if (rd_vld && rd_rdy) begin
              if (rd_last) begin
                rd_vld  <= 1'b0;
                rd_last <= 1'b0;
                rd_busy <= 1'b0;
                state   <= RDY;
              end else begin
                rd_row  <= rd_word[RW+VW-1:VW];
                rd_val  <= rd_word[VW-1:0];
                rd_last <= next_last;
                rd_ptr  <= rd_ptr + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csc_mat_stor.sv
// Directed self-checking bench for csc_mat_stor (MAT_RANK=8, NNZ_MAX=8, CH=1, DW=16).
module tb_csc_mat_stor;

  localparam int MAT_RANK = 8;
  localparam int NNZ_MAX  = 8;
  localparam int DW       = 16;
  localparam int CH       = 1;
  localparam int RW       = 3;
  localparam int PW       = 4;
  localparam int VW       = 32;

  logic          clk, rst;
  logic          wr_start, wr_vld, wr_rdy, wr_last;
  logic [RW-1:0] wr_col, wr_row;
  logic [VW-1:0] wr_val;
  logic          rd_req, rd_busy, rd_vld, rd_rdy, rd_last, rd_empty;
  logic [RW-1:0] rd_col, rd_row;
  logic [VW-1:0] rd_val;
  logic          done, err_ovf, err_ord;
  logic [PW-1:0] nnz;

  csc_mat_stor #(.MAT_RANK(MAT_RANK), .NNZ_MAX(NNZ_MAX), .DW(DW), .CH(CH)) dut (
    .clk(clk), .rst(rst),
    .wr_start(wr_start), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
    .wr_col(wr_col), .wr_row(wr_row), .wr_val(wr_val), .wr_last(wr_last),
    .rd_req(rd_req), .rd_col(rd_col), .rd_busy(rd_busy),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_row(rd_row), .rd_val(rd_val),
    .rd_last(rd_last), .rd_empty(rd_empty),
    .done(done), .nnz(nnz), .err_ovf(err_ovf), .err_ord(err_ord)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Beats captured by do_read
  int            b_n, first_k, last_k, empty_cnt, empty_k;
  logic [RW-1:0] b_row  [16];
  logic [VW-1:0] b_val  [16];
  logic          b_last [16];

  task automatic start_load();
    wr_start = 1'b1;
    @(posedge clk); #1;
    wr_start = 1'b0;
  endtask

  task automatic write_entry(input int col, input int row, input logic [VW-1:0] val,
                             input logic last, output int stalls);
    logic ok;
    logic [RW-1:0] c, r;
    c = col[RW-1:0];
    r = row[RW-1:0];
    wr_vld = 1'b1; wr_col = c; wr_row = r; wr_val = val; wr_last = last;
    stalls = 0;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      ok = wr_rdy;
      @(posedge clk); #1;
      if (ok) break;
      stalls++;
    end
    wr_vld = 1'b0; wr_last = 1'b0;
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL write_timeout: col %0d wr_rdy never high", col); end
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = done;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL done_timeout: done got 0 want 1"); end
  endtask

  // Issue a read of one column and record 30 cycles of output; mode 1 toggles rd_rdy 0,1.
  task automatic do_read(input int col, input int mode);
    logic          hold_pend;
    logic [RW-1:0] h_row;
    logic [VW-1:0] h_val;
    logic          h_last;
    logic [RW-1:0] c;
    c = col[RW-1:0];
    b_n = 0; first_k = -1; last_k = -1; empty_cnt = 0; empty_k = -1;
    hold_pend = 1'b0; h_row = '0; h_val = '0; h_last = 1'b0;
    rd_col = c; rd_req = 1'b1; rd_rdy = 1'b0;
    @(posedge clk); #1;
    rd_req = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      rd_rdy = (mode == 0) || (k % 2 == 0);
      @(negedge clk);
      if (hold_pend) begin
        n_checks++;
        if (rd_vld !== 1'b1 || rd_row !== h_row || rd_val !== h_val || rd_last !== h_last) begin
          n_errors++;
          $display("FAIL hold_c%0d: got vld=%b row=%0d val=%h last=%b want vld=1 row=%0d val=%h last=%b",
                   col, rd_vld, rd_row, rd_val, rd_last, h_row, h_val, h_last);
        end
      end
      hold_pend = rd_vld && !rd_rdy;
      h_row = rd_row; h_val = rd_val; h_last = rd_last;
      if (rd_empty) begin empty_cnt++; if (empty_k < 0) empty_k = k; end
      if (rd_vld && first_k < 0) first_k = k;
      if (rd_vld && rd_rdy && b_n < 16) begin
        b_row[b_n] = rd_row; b_val[b_n] = rd_val; b_last[b_n] = rd_last;
        b_n++;
        last_k = k;
      end
      @(posedge clk); #1;
    end
    rd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_start = 0; wr_vld = 0; wr_col = 0; wr_row = 0; wr_val = 0; wr_last = 0;
    rd_req = 0; rd_col = 0; rd_rdy = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({done, wr_rdy, rd_vld, rd_busy, rd_last, rd_empty, err_ovf, err_ord} !== 8'b0 || nnz !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got done=%b wr_rdy=%b rd_vld=%b busy=%b last=%b empty=%b ovf=%b ord=%b nnz=%0d want all 0",
               done, wr_rdy, rd_vld, rd_busy, rd_last, rd_empty, err_ovf, err_ord, nnz);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_basic();
    int s0, s1, s2;
    start_load();
    write_entry(0, 2, 32'hA1A1_0A0A, 1'b0, s0);
    write_entry(0, 5, 32'hB2B2_0B0B, 1'b0, s1);
    write_entry(3, 1, 32'hC3C3_0C0C, 1'b1, s2);
    n_checks++;
    if (s0 != 0 || s1 != 0 || s2 != 3) begin
      n_errors++; $display("FAIL load_stalls: got %0d,%0d,%0d want 0,0,3", s0, s1, s2);
    end
    wait_done();
    n_checks++;
    if (nnz !== 4'd3) begin n_errors++; $display("FAIL load_nnz: got %0d want 3", nnz); end
  endtask

  task automatic test_read();
    logic [RW-1:0] er [2];
    logic [VW-1:0] ev [2];
    er[0] = 3'd2; er[1] = 3'd5; ev[0] = 32'hA1A1_0A0A; ev[1] = 32'hB2B2_0B0B;
    do_read(0, 0);
    n_checks++;
    if (b_n != 2 || first_k != 3) begin
      n_errors++; $display("FAIL read_c0_count: got n=%0d first=%0d want n=2 first=3", b_n, first_k);
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (b_row[i] !== er[i] || b_val[i] !== ev[i] || b_last[i] !== (i == 1)) begin
        n_errors++;
        $display("FAIL read_c0_beat%0d: got row=%0d val=%h last=%b want row=%0d val=%h last=%b",
                 i, b_row[i], b_val[i], b_last[i], er[i], ev[i], (i == 1));
      end
    end
    do_read(3, 0);
    n_checks++;
    if (b_n != 1 || b_row[0] !== 3'd1 || b_val[0] !== 32'hC3C3_0C0C || b_last[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL read_c3: got n=%0d row=%0d val=%h last=%b want n=1 row=1 val=c3c30c0c last=1",
               b_n, b_row[0], b_val[0], b_last[0]);
    end
    do_read(7, 0);
    n_checks++;
    if (b_n != 0 || empty_cnt != 1) begin
      n_errors++; $display("FAIL read_c7_empty: got n=%0d empty=%0d want n=0 empty=1", b_n, empty_cnt);
    end
  endtask

  task automatic test_empty();
    do_read(1, 0);
    n_checks++;
    if (empty_cnt != 1 || empty_k != 3 || first_k != -1) begin
      n_errors++;
      $display("FAIL empty_c1: got pulses=%0d at=%0d vld_at=%0d want pulses=1 at=3 vld_at=-1",
               empty_cnt, empty_k, first_k);
    end
    n_checks++;
    if (rd_busy !== 1'b0 || done !== 1'b1) begin
      n_errors++; $display("FAIL empty_idle: got busy=%b done=%b want busy=0 done=1", rd_busy, done);
    end
  endtask

  task automatic test_overflow();
    int s, tot;
    logic [VW-1:0] v;
    tot = 0;
    start_load();
    for (int i = 0; i < 10; i++) begin
      v = 32'h0000_0100 + i;
      write_entry(0, i % 8, v, (i == 9), s);
      tot += s;
    end
    wait_done();
    n_checks++;
    if (tot != 0) begin n_errors++; $display("FAIL ovf_stalls: got %0d want 0", tot); end
    n_checks++;
    if (nnz !== 4'd8 || err_ovf !== 1'b1) begin
      n_errors++; $display("FAIL ovf_flags: got nnz=%0d ovf=%b want nnz=8 ovf=1", nnz, err_ovf);
    end
    do_read(0, 0);
    n_checks++;
    if (b_n != 8) begin n_errors++; $display("FAIL ovf_read_count: got %0d want 8", b_n); end
    for (int i = 0; i < 8; i++) begin
      v = 32'h0000_0100 + i;
      n_checks++;
      if (b_row[i] !== 3'(i) || b_val[i] !== v || b_last[i] !== (i == 7)) begin
        n_errors++;
        $display("FAIL ovf_beat%0d: got row=%0d val=%h last=%b want row=%0d val=%h last=%b",
                 i, b_row[i], b_val[i], b_last[i], i, v, (i == 7));
      end
    end
  endtask

  task automatic test_order();
    int s;
    start_load();
    write_entry(2, 0, 32'h1111_2222, 1'b0, s);
    write_entry(1, 3, 32'h3333_4444, 1'b1, s);
    wait_done();
`ifdef CSC_MAT_STOR_ORDER_CHK_EN
    n_checks++;
    if (err_ord !== 1'b1 || nnz !== 4'd1) begin
      n_errors++; $display("FAIL ord_flags: got ord=%b nnz=%0d want ord=1 nnz=1", err_ord, nnz);
    end
    do_read(1, 0);
    n_checks++;
    if (b_n != 0 || empty_cnt != 1) begin
      n_errors++; $display("FAIL ord_c1_empty: got n=%0d empty=%0d want n=0 empty=1", b_n, empty_cnt);
    end
    do_read(2, 0);
    n_checks++;
    if (b_n != 1 || b_row[0] !== 3'd0 || b_val[0] !== 32'h1111_2222 || b_last[0] !== 1'b1) begin
      n_errors++; $display("FAIL ord_c2: got n=%0d row=%0d val=%h want n=1 row=0 val=11112222", b_n, b_row[0], b_val[0]);
    end
`else
    n_checks++;
    if (err_ord !== 1'b0 || nnz !== 4'd2) begin
      n_errors++; $display("FAIL ord_flags: got ord=%b nnz=%0d want ord=0 nnz=2", err_ord, nnz);
    end
    do_read(2, 0);
    n_checks++;
    if (b_n != 2 || b_row[0] !== 3'd0 || b_val[0] !== 32'h1111_2222 || b_last[0] !== 1'b0 ||
        b_row[1] !== 3'd3 || b_val[1] !== 32'h3333_4444 || b_last[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL ord_c2: got n=%0d rows=%0d,%0d vals=%h,%h want n=2 rows=0,3 vals=11112222,33334444",
               b_n, b_row[0], b_row[1], b_val[0], b_val[1]);
    end
`endif
  endtask

  task automatic load_col5();
    int s;
    logic [VW-1:0] v;
    start_load();
    for (int i = 0; i < 4; i++) begin
      v = 32'h5500_0000 + (i * 17);
      write_entry(5, 3 - i, v, (i == 3), s);
    end
    wait_done();
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] v;
    load_col5();
    for (int m = 0; m < 2; m++) begin
      do_read(5, m);
      n_checks++;
      if (b_n != 4 || first_k != 3 || (m == 0 && last_k - first_k != 3)) begin
        n_errors++;
        $display("FAIL stream_m%0d_timing: got n=%0d first=%0d last=%0d want n=4 first=3 span=3 (mode0)",
                 m, b_n, first_k, last_k);
      end
      for (int i = 0; i < 4; i++) begin
        v = 32'h5500_0000 + (i * 17);
        n_checks++;
        if (b_row[i] !== 3'(3 - i) || b_val[i] !== v || b_last[i] !== (i == 3)) begin
          n_errors++;
          $display("FAIL stream_m%0d_beat%0d: got row=%0d val=%h last=%b want row=%0d val=%h last=%b",
                   m, i, b_row[i], b_val[i], b_last[i], 3 - i, v, (i == 3));
        end
      end
      n_checks++;
      if (rd_busy !== 1'b0) begin n_errors++; $display("FAIL stream_m%0d_busy: got 1 want 0", m); end
    end
  endtask

  // Issue a read with rd_rdy low and wait for the first beat to be presented.
  task automatic stall_read_c5(input string tag);
    logic seen;
    seen = 1'b0;
    rd_col = 3'd5; rd_rdy = 1'b0; rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = rd_vld;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL %s_vld_timeout: got rd_vld=0 want 1", tag); end
  endtask

  task automatic test_rst_mid();
    stall_read_c5("rstmid");
    rst = 1'b1;
    #1;
    n_checks++;
    if (rd_vld !== 1'b0 || rd_busy !== 1'b0 || done !== 1'b0 || nnz !== 4'd0 || wr_rdy !== 1'b0) begin
      n_errors++;
      $display("FAIL rstmid_outputs: got vld=%b busy=%b done=%b nnz=%0d wr_rdy=%b want all 0",
               rd_vld, rd_busy, done, nnz, wr_rdy);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_start_mid();
    load_col5();
    stall_read_c5("startmid");
    start_load();
    n_checks++;
    if (rd_vld !== 1'b0 || rd_busy !== 1'b0 || wr_rdy !== 1'b1 || done !== 1'b0 || nnz !== 4'd0) begin
      n_errors++;
      $display("FAIL startmid_outputs: got vld=%b busy=%b wr_rdy=%b done=%b nnz=%0d want 0,0,1,0,0",
               rd_vld, rd_busy, wr_rdy, done, nnz);
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_read();
    test_empty();
    test_overflow();
    test_order();
    test_back_to_back();
    test_rst_mid();
    test_start_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
